// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences multi-frame capture requests over the frame-capture state machine.
// Optional CAPTURE_WATCHDOG_EN adds start/done timeouts that fault the request.
module capture_ctrl #(
    parameter int FRAME_W   = 4,
    parameter int TIMEOUT_W = 22,
    parameter int START_TO  = 1000,
    parameter int DONE_TO   = 2000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic [FRAME_W-1:0] num_frames,
    input  logic               clr,
    input  logic               photo_started,
    input  logic               photo_done,
    input  logic               photo_error,
    output logic               photo_start,
    output logic               photo_ack,
    output logic               busy,
    output logic               buf_sel,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               cap_done,
    output logic               cap_err,
    output logic [1:0]         err_code
);
    typedef enum logic [2:0] {IDLE, START, WAIT_DONE, ACK, FINISH, FAULT} state_t;

    state_t             state, state_nx;
    logic [FRAME_W-1:0] n, n_nx, frame_cnt_nx;
    logic               buf_sel_nx;
    logic [1:0]         err_code_nx;
    logic               start_to, done_to;

`ifdef CAPTURE_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd;
    assign start_to = (state == START) && (wd == TIMEOUT_W'(START_TO - 1));
    assign done_to  = (state == WAIT_DONE) && (wd == TIMEOUT_W'(DONE_TO - 1));
    // Restarts on every state entry, so each frame gets a fresh budget.
    always_ff @(posedge clk or negedge reset)
        if (!reset) wd <= '0;
        else        wd <= (state_nx != state || !(state inside {START, WAIT_DONE})) ? '0 : wd + 1'b1;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_W, START_TO, DONE_TO};
    assign start_to   = 1'b0;
    assign done_to    = 1'b0;
`endif

    always_comb begin
        state_nx     = state;
        n_nx         = n;
        frame_cnt_nx = frame_cnt;
        buf_sel_nx   = buf_sel;
        err_code_nx  = err_code;
        if (photo_error && state inside {START, WAIT_DONE, ACK}) begin
            state_nx    = FAULT;
            err_code_nx = 2'b01;
        end else if (start_to && !photo_started) begin
            state_nx    = FAULT;
            err_code_nx = 2'b10;
        end else if (done_to && !photo_done) begin
            state_nx    = FAULT;
            err_code_nx = 2'b11;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state_nx     = START;
                    n_nx         = (num_frames == '0) ? FRAME_W'(1) : num_frames;
                    frame_cnt_nx = '0;
                    buf_sel_nx   = 1'b0;
                end
                START:     if (photo_started) state_nx = WAIT_DONE;
                WAIT_DONE: if (photo_done) state_nx = ACK;
                ACK: if (!photo_done) begin
                    frame_cnt_nx = frame_cnt + 1'b1;
                    buf_sel_nx   = !buf_sel;
                    state_nx     = (frame_cnt_nx == n) ? FINISH : START;
                end
                FINISH: if (clr) state_nx = IDLE;
                FAULT: if (clr) begin
                    state_nx    = IDLE;
                    err_code_nx = 2'b00;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state       <= IDLE;
            n           <= FRAME_W'(1);
            frame_cnt   <= '0;
            buf_sel     <= 1'b0;
            err_code    <= 2'b00;
            photo_start <= 1'b0;
            photo_ack   <= 1'b0;
            busy        <= 1'b0;
            cap_done    <= 1'b0;
            cap_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            n           <= n_nx;
            frame_cnt   <= frame_cnt_nx;
            buf_sel     <= buf_sel_nx;
            err_code    <= err_code_nx;
            photo_start <= state_nx == START;
            photo_ack   <= state_nx == ACK;
            busy        <= state_nx != IDLE;
            cap_done    <= state_nx == FINISH;
            cap_err     <= state_nx == FAULT;
        end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: randomized scenario bench for capture_ctrl with a behavioural capture-SM responder.
module tb_capture_ctrl;
`ifdef CAPTURE_WATCHDOG_EN
    localparam int S_TO = 16, D_TO = 24;
`else
    localparam int S_TO = 1000, D_TO = 2000000;
`endif
    logic       clk = 0, reset = 0, req = 0, clr = 0;
    logic [3:0] num_frames = 0;
    logic       photo_started = 0, photo_done = 0, photo_error = 0;
    logic       photo_start, photo_ack, busy, buf_sel, cap_done, cap_err;
    logic [3:0] frame_cnt;
    logic [1:0] err_code;
    int         cmp = 0, fails = 0;
    bit         noise = 0;

    capture_ctrl #(.FRAME_W(4), .TIMEOUT_W(22), .START_TO(S_TO), .DONE_TO(D_TO)) dut (
        .clk(clk), .reset(reset), .req(req), .num_frames(num_frames), .clr(clr),
        .photo_started(photo_started), .photo_done(photo_done), .photo_error(photo_error),
        .photo_start(photo_start), .photo_ack(photo_ack), .busy(busy), .buf_sel(buf_sel),
        .frame_cnt(frame_cnt), .cap_done(cap_done), .cap_err(cap_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        if (noise) begin
            req = 1'($urandom_range(0, 1));
            clr = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_start(output bit ok);
        int t = 0;
        while (photo_start !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        ok = (photo_start === 1'b1);
    endtask

    // Reference: n = max(num_frames,1); frame k is written to buffer k%2; final count n, final buf n%2.
    task automatic do_request(input logic [3:0] nf, input int maxd, input bit noisy, input bit do_clr);
        int n = (nf == 0) ? 1 : int'(nf);
        bit ok;
        req = 1; num_frames = nf;
        tick();
        req = 0; num_frames = 4'($urandom);
        noise = noisy;
        for (int k = 0; k < n; k++) begin
            wait_start(ok);
            cmp++; if (!ok) begin fails++; $display("FAIL start_wait frame %0d: photo_start=%b required 1", k, photo_start); end
            cmp++; if (buf_sel !== k[0] || frame_cnt !== 4'(k)) begin fails++; $display("FAIL frame_pre %0d: buf_sel=%b frame_cnt=%0d required %b %0d", k, buf_sel, frame_cnt, k[0], k); end
            repeat ($urandom_range(0, maxd)) tick();
            cmp++; if (photo_start !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL start_hold %0d: photo_start=%b busy=%b required 1 1", k, photo_start, busy); end
            photo_started = 1; tick(); photo_started = 0;
            cmp++; if (photo_start !== 1'b0 || photo_ack !== 1'b0) begin fails++; $display("FAIL wait_done %0d: start=%b ack=%b required 0 0", k, photo_start, photo_ack); end
            repeat ($urandom_range(0, maxd)) tick();
            photo_done = 1; tick();
            repeat ($urandom_range(0, maxd)) tick();
            cmp++; if (photo_ack !== 1'b1) begin fails++; $display("FAIL ack_hold %0d: photo_ack=%b required 1", k, photo_ack); end
            if (k == n - 1) begin noise = 0; req = 0; clr = 0; end
            photo_done = 0; tick();
            cmp++; if (photo_ack !== 1'b0 || frame_cnt !== 4'(k + 1) || buf_sel !== 1'((k + 1) % 2)) begin fails++; $display("FAIL frame_post %0d: ack=%b frame_cnt=%0d buf_sel=%b required 0 %0d %0d", k, photo_ack, frame_cnt, buf_sel, k + 1, (k + 1) % 2); end
        end
        cmp++; if (cap_done !== 1'b1 || busy !== 1'b1 || cap_err !== 1'b0 || photo_start !== 1'b0 || frame_cnt !== 4'(n)) begin fails++; $display("FAIL finish nf=%0d: done=%b busy=%b err=%b start=%b cnt=%0d required 1 1 0 0 %0d", nf, cap_done, busy, cap_err, photo_start, frame_cnt, n); end
        if (do_clr) begin
            clr = 1; tick(); clr = 0;
            cmp++; if (busy !== 1'b0 || cap_done !== 1'b0 || frame_cnt !== 4'(n)) begin fails++; $display("FAIL clr_finish nf=%0d: busy=%b done=%b cnt=%0d required 0 0 %0d", nf, busy, cap_done, frame_cnt, n); end
        end
    endtask

    task automatic test_reset();
        bit ok;
        repeat (3) tick();
        cmp++; if ({photo_start, photo_ack, busy, buf_sel, frame_cnt, cap_done, cap_err, err_code} !== 12'd0) begin fails++; $display("FAIL reset_state: outputs=%b required 0", {photo_start, photo_ack, busy, buf_sel, frame_cnt, cap_done, cap_err, err_code}); end
        reset = 1; tick();
        cmp++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle: busy=%b required 0", busy); end
        req = 1; num_frames = 2; tick(); req = 0;
        wait_start(ok);
        photo_started = 1; tick(); photo_started = 0;
        photo_done = 1; tick();
        cmp++; if (photo_ack !== 1'b1) begin fails++; $display("FAIL reset_pre_ack: photo_ack=%b required 1", photo_ack); end
        #2 reset = 0; #1;
        cmp++; if ({photo_start, photo_ack, busy, buf_sel, frame_cnt, cap_done, cap_err, err_code} !== 12'd0) begin fails++; $display("FAIL reset_mid_ack: outputs=%b required 0", {photo_start, photo_ack, busy, buf_sel, frame_cnt, cap_done, cap_err, err_code}); end
        photo_done = 0;
        tick(); reset = 1; tick();
        cmp++; if (busy !== 1'b0 || photo_start !== 1'b0 || photo_ack !== 1'b0) begin fails++; $display("FAIL reset_release: busy=%b start=%b ack=%b required 0 0 0", busy, photo_start, photo_ack); end
    endtask

    task automatic test_three_frames(); do_request(4'd3, 3, 0, 1); endtask
    task automatic test_zero_frames();  do_request(4'd0, 2, 0, 1); endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) do_request(4'($urandom_range(0, 15)), 4, 1, 1);
    endtask

    task automatic test_error();
        bit ok;
        photo_error = 1; tick(); photo_error = 0;
        cmp++; if (cap_err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL error_idle: cap_err=%b busy=%b required 0 0", cap_err, busy); end
        req = 1; num_frames = 3; tick(); req = 0;
        wait_start(ok);
        photo_started = 1; tick(); photo_started = 0;
        photo_done = 1; tick(); photo_done = 0; tick();
        wait_start(ok);
        cmp++; if (!ok || frame_cnt !== 4'd1) begin fails++; $display("FAIL error_frame2: start=%b cnt=%0d required 1 1", photo_start, frame_cnt); end
        photo_started = 1; tick(); photo_started = 0;
        photo_error = 1; tick(); photo_error = 0;
        cmp++; if (cap_err !== 1'b1 || err_code !== 2'b01 || photo_start !== 1'b0 || photo_ack !== 1'b0 || busy !== 1'b1 || frame_cnt !== 4'd1) begin fails++; $display("FAIL error_fault: err=%b code=%b start=%b ack=%b busy=%b cnt=%0d required 1 01 0 0 1 1", cap_err, err_code, photo_start, photo_ack, busy, frame_cnt); end
        req = 1; repeat (3) tick(); req = 0;
        cmp++; if (cap_err !== 1'b1 || err_code !== 2'b01 || photo_start !== 1'b0) begin fails++; $display("FAIL error_hold: err=%b code=%b start=%b required 1 01 0", cap_err, err_code, photo_start); end
        clr = 1; tick(); clr = 0;
        cmp++; if (busy !== 1'b0 || cap_err !== 1'b0 || err_code !== 2'b00) begin fails++; $display("FAIL error_clr: busy=%b err=%b code=%b required 0 0 00", busy, cap_err, err_code); end
    endtask

    task automatic test_timeout();
        req = 1; num_frames = 1; tick(); req = 0;
`ifdef CAPTURE_WATCHDOG_EN
        repeat (S_TO - 1) tick();
        cmp++; if (cap_err !== 1'b0 || photo_start !== 1'b1) begin fails++; $display("FAIL start_to_early: err=%b start=%b required 0 1", cap_err, photo_start); end
        tick();
        cmp++; if (cap_err !== 1'b1 || err_code !== 2'b10 || photo_start !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL start_to: err=%b code=%b start=%b busy=%b required 1 10 0 1", cap_err, err_code, photo_start, busy); end
        clr = 1; tick(); clr = 0;
        cmp++; if (busy !== 1'b0 || err_code !== 2'b00) begin fails++; $display("FAIL start_to_clr: busy=%b code=%b required 0 00", busy, err_code); end
        req = 1; tick(); req = 0;
        repeat (S_TO - 1) tick();
        photo_started = 1; tick(); photo_started = 0;
        cmp++; if (cap_err !== 1'b0 || photo_start !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL start_expiry_event: err=%b start=%b busy=%b required 0 0 1", cap_err, photo_start, busy); end
        repeat (D_TO - 1) tick();
        cmp++; if (cap_err !== 1'b0) begin fails++; $display("FAIL done_to_early: err=%b required 0", cap_err); end
        tick();
        cmp++; if (cap_err !== 1'b1 || err_code !== 2'b11) begin fails++; $display("FAIL done_to: err=%b code=%b required 1 11", cap_err, err_code); end
`else
        repeat (10000) tick();
        cmp++; if (photo_start !== 1'b1 || busy !== 1'b1 || cap_err !== 1'b0 || err_code !== 2'b00) begin fails++; $display("FAIL no_watchdog: start=%b busy=%b err=%b code=%b required 1 1 0 00", photo_start, busy, cap_err, err_code); end
        photo_error = 1; tick(); photo_error = 0;
        cmp++; if (cap_err !== 1'b1 || err_code !== 2'b01) begin fails++; $display("FAIL error_in_start: err=%b code=%b required 1 01", cap_err, err_code); end
`endif
        clr = 1; tick(); clr = 0;
        cmp++; if (busy !== 1'b0 || cap_err !== 1'b0 || err_code !== 2'b00) begin fails++; $display("FAIL timeout_clr: busy=%b err=%b code=%b required 0 0 00", busy, cap_err, err_code); end
    endtask

    task automatic test_clr_req();
        do_request(4'd1, 1, 0, 0);
        clr = 1; req = 1; num_frames = 2; tick(); clr = 0;
        cmp++; if (busy !== 1'b0 || cap_done !== 1'b0 || photo_start !== 1'b0 || frame_cnt !== 4'd1) begin fails++; $display("FAIL clr_wins: busy=%b done=%b start=%b cnt=%0d required 0 0 0 1", busy, cap_done, photo_start, frame_cnt); end
        tick(); req = 0;
        cmp++; if (photo_start !== 1'b1 || busy !== 1'b1 || frame_cnt !== 4'd0 || buf_sel !== 1'b0) begin fails++; $display("FAIL req_after_clr: start=%b busy=%b cnt=%0d sel=%b required 1 1 0 0", photo_start, busy, frame_cnt, buf_sel); end
        reset = 0; tick(); reset = 1; tick();
    endtask

    initial begin
        test_reset();
        test_three_frames();
        test_zero_frames();
        test_error();
        test_timeout();
        test_clr_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end
endmodule
